// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG request scheduler.
// Holds the scheduler state encoding, the owner encoding and the default word width.
package trng_pkg;

    localparam int WORD_W_DEFAULT = 64;

    localparam logic OWNER_GEN  = 1'b0;
    localparam logic OWNER_STAT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    // Round-robin pick: on a tie the requester not served last wins.
    function automatic logic pick_owner(input logic g_req, input logic s_req, input logic last_served);
        if (g_req && s_req) begin
            return ~last_served;
        end
        return s_req ? OWNER_STAT : OWNER_GEN;
    endfunction

endpackage

// File: rtl/trng_ready_sync.sv
// Three-flop synchronizer for the RO ready strobe with a rising-edge output.
// s1/s2 resolve metastability, s3 holds the previous synchronized level.
module trng_ready_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/trng_req_scheduler.sv
// Round-robin sharing of the RO entropy source between bit-gen and the stat test.
// Optional watchdog on the ready wait is enabled by defining TRNG_SCHED_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | source disabled, waiting for a request
// WAIT    | source enabled, discarding warm-up words until capture
// DELIVER | word captured, owner's valid pulse is high, source disabled
module trng_req_scheduler
    import trng_pkg::*;
#(
    parameter int WORD_W        = WORD_W_DEFAULT,
    parameter int DISCARD_WORDS = 1,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic              clk,
    input  logic              trng_rst_n,
    input  logic              gen_req,
    input  logic              stat_req,
    output logic              gen_valid,
    output logic              stat_valid,
    output logic [WORD_W-1:0] rnd_word,
    output logic              owner,
    output logic              busy,
    output logic              tro_enable,
    input  logic [WORD_W-1:0] tro_word,
    input  logic              tro_ready,
    output logic              timeout_err
);

    if (DISCARD_WORDS < 0 || DISCARD_WORDS > 15 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("trng_req_scheduler: DISCARD_WORDS must be 0..15 and TIMEOUT_CYC >= 1");
    end

    localparam logic [3:0] DISC_INIT = 4'(DISCARD_WORDS);
    localparam logic [1:0] ARM_DONE  = 2'd2;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [3:0]        disc_q, disc_d;
    logic [1:0]        arm_q, arm_d;
    logic [WORD_W-1:0] rnd_word_q, rnd_word_d;
    logic              gen_valid_q, gen_valid_d;
    logic              stat_valid_q, stat_valid_d;
    logic              tro_enable_q, tro_enable_d;

    logic ready_rise;
    logic owner_req;
    logic edge_ok;
    logic deliver;

`ifdef TRNG_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    trng_ready_sync u_ready_sync (
        .clk      (clk),
        .rst_n    (trng_rst_n),
        .async_in (tro_ready),
        .rise     (ready_rise)
    );

    assign owner_req = (owner_q == OWNER_STAT) ? stat_req : gen_req;

    // The first two WAIT cycles only see ready levels sampled before the enable rose.
    assign edge_ok = ready_rise && (arm_q == ARM_DONE);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        disc_d       = disc_q;
        arm_d        = arm_q;
        rnd_word_d   = rnd_word_q;
        gen_valid_d  = 1'b0;
        stat_valid_d = 1'b0;
        deliver      = 1'b0;
`ifdef TRNG_SCHED_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (gen_req || stat_req) begin
                    owner_d = pick_owner(gen_req, stat_req, last_q);
                    disc_d  = DISC_INIT;
                    arm_d   = 2'd0;
                    state_d = ST_WAIT;
`ifdef TRNG_SCHED_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (arm_q != ARM_DONE) begin
                    arm_d = arm_q + 2'd1;
                end
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else if (edge_ok) begin
`ifdef TRNG_SCHED_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                    if (disc_q != 4'd0) begin
                        disc_d = disc_q - 4'd1;
                    end else begin
                        rnd_word_d = tro_word;
                        deliver    = 1'b1;
                    end
                end
`ifdef TRNG_SCHED_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_cnt_d     = TMO_MAX;
                    timeout_err_d = 1'b1;
                    rnd_word_d    = '0;
                    deliver       = 1'b1;
                end else if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_DELIVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (deliver) begin
            state_d      = ST_DELIVER;
            gen_valid_d  = (owner_q == OWNER_GEN);
            stat_valid_d = (owner_q == OWNER_STAT);
            last_d       = owner_q;
        end

        tro_enable_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk or negedge trng_rst_n) begin
        if (!trng_rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_GEN;
            last_q       <= OWNER_STAT;
            disc_q       <= 4'd0;
            arm_q        <= 2'd0;
            rnd_word_q   <= '0;
            gen_valid_q  <= 1'b0;
            stat_valid_q <= 1'b0;
            tro_enable_q <= 1'b0;
`ifdef TRNG_SCHED_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            disc_q       <= disc_d;
            arm_q        <= arm_d;
            rnd_word_q   <= rnd_word_d;
            gen_valid_q  <= gen_valid_d;
            stat_valid_q <= stat_valid_d;
            tro_enable_q <= tro_enable_d;
`ifdef TRNG_SCHED_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign gen_valid  = gen_valid_q;
    assign stat_valid = stat_valid_q;
    assign rnd_word   = rnd_word_q;
    assign owner      = owner_q;
    assign busy       = (state_q != ST_IDLE);
    assign tro_enable = tro_enable_q;

`ifdef TRNG_SCHED_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_trng_req_scheduler.sv
// Directed bench for trng_req_scheduler: round-robin, discard, abort, ready pre-high,
// reset mid-WAIT and (with TRNG_SCHED_TIMEOUT_EN) the watchdog path.
`timescale 1ns/1ps
module tb_trng_req_scheduler;

    logic        clk        = 1'b0;
    logic        trng_rst_n = 1'b0;
    logic        gen_req    = 1'b0;
    logic        stat_req   = 1'b0;
    logic        tro_ready  = 1'b0;
    logic [63:0] tro_word   = '0;
    logic        gen_valid, stat_valid, owner, busy, tro_enable, timeout_err;
    logic [63:0] rnd_word;

    int tests = 0;
    int fails = 0;

    int          gen_cnt, stat_cnt, both_cnt, en_bad;
    logic        prev_valid;
    logic [63:0] gen_word, stat_word;
    logic        owner_log[$];

    always #5 clk = ~clk;

    trng_req_scheduler #(
        .WORD_W        (64),
        .DISCARD_WORDS (1),
        .TIMEOUT_CYC   (32)
    ) dut (
        .clk         (clk),
        .trng_rst_n  (trng_rst_n),
        .gen_req     (gen_req),
        .stat_req    (stat_req),
        .gen_valid   (gen_valid),
        .stat_valid  (stat_valid),
        .rnd_word    (rnd_word),
        .owner       (owner),
        .busy        (busy),
        .tro_enable  (tro_enable),
        .tro_word    (tro_word),
        .tro_ready   (tro_ready),
        .timeout_err (timeout_err)
    );

    // One clock, sampled 1 ns after the edge; requesters drop their level on seeing valid.
    task automatic step();
        @(posedge clk);
        #1;
        if ((prev_valid || gen_valid || stat_valid) && tro_enable) en_bad++;
        if (gen_valid && stat_valid) both_cnt++;
        if (gen_valid) begin
            gen_cnt++;
            gen_word = rnd_word;
            owner_log.push_back(owner);
            gen_req = 1'b0;
        end
        if (stat_valid) begin
            stat_cnt++;
            stat_word = rnd_word;
            owner_log.push_back(owner);
            stat_req = 1'b0;
        end
        prev_valid = gen_valid | stat_valid;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_mon();
        gen_cnt = 0; stat_cnt = 0; both_cnt = 0; en_bad = 0;
        prev_valid = 1'b0; gen_word = '0; stat_word = '0;
        owner_log.delete();
    endtask

    task automatic ro_pulse(input logic [63:0] w);
        tro_word  = w;
        tro_ready = 1'b1;
        steps(6);
        tro_ready = 1'b0;
        steps(4);
    endtask

    task automatic do_reset();
        trng_rst_n = 1'b0;
        gen_req = 1'b0; stat_req = 1'b0; tro_ready = 1'b0;
        steps(3);
        trng_rst_n = 1'b1;
        steps(1);
        clear_mon();
    endtask

    task automatic test_reset();
        trng_rst_n = 1'b0;
        steps(2);
        tests++;
        if ({gen_valid, stat_valid, owner, busy, tro_enable, timeout_err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 000000", {gen_valid, stat_valid, owner, busy, tro_enable, timeout_err});
        end
        tests++;
        if (rnd_word !== 64'h0) begin
            fails++;
            $display("FAIL reset_word: got %h expected 0", rnd_word);
        end
        do_reset();
    endtask

    task automatic test_gen_only();
        do_reset();
        gen_req = 1'b1;
        step();
        tests++;
        if (tro_enable !== 1'b1) begin
            fails++;
            $display("FAIL gen_en_latency: got %b expected 1", tro_enable);
        end
        ro_pulse(64'hAAAA_0000_1111_2222);
        ro_pulse(64'hBBBB_3333_4444_5555);
        steps(3);
        tests++;
        if (gen_cnt !== 1 || stat_cnt !== 0) begin
            fails++;
            $display("FAIL gen_pulses: got gen=%0d stat=%0d expected gen=1 stat=0", gen_cnt, stat_cnt);
        end
        tests++;
        if (gen_word !== 64'hBBBB_3333_4444_5555) begin
            fails++;
            $display("FAIL gen_word: got %h expected bbbb333344445555", gen_word);
        end
        tests++;
        if (rnd_word !== 64'hBBBB_3333_4444_5555) begin
            fails++;
            $display("FAIL gen_word_held: got %h expected bbbb333344445555", rnd_word);
        end
        tests++;
        if (en_bad !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL gen_enable_off: got en_bad=%0d busy=%b expected 0 0", en_bad, busy);
        end
    endtask

    task automatic test_tie();
        do_reset();
        gen_req = 1'b1; stat_req = 1'b1;
        step();
        tests++;
        if (owner !== 1'b0) begin
            fails++;
            $display("FAIL tie_first_owner: got %b expected 0", owner);
        end
        ro_pulse(64'h0000_0000_0000_000C);
        ro_pulse(64'h0000_0000_0000_000D);
        ro_pulse(64'h0000_0000_0000_000E);
        ro_pulse(64'h0000_0000_0000_000F);
        steps(3);
        tests++;
        if (owner_log.size() !== 2) begin
            fails++;
            $display("FAIL tie_grants: got %0d expected 2", owner_log.size());
        end else begin
            tests++;
            if (owner_log[0] !== 1'b0 || owner_log[1] !== 1'b1) begin
                fails++;
                $display("FAIL tie_order: got %b,%b expected 0,1", owner_log[0], owner_log[1]);
            end
        end
        tests++;
        if (gen_word !== 64'hD || stat_word !== 64'hF) begin
            fails++;
            $display("FAIL tie_words: got gen=%h stat=%h expected d f", gen_word, stat_word);
        end
        tests++;
        if (both_cnt !== 0 || en_bad !== 0) begin
            fails++;
            $display("FAIL tie_exclusive: got both=%0d en_bad=%0d expected 0 0", both_cnt, en_bad);
        end
    endtask

    task automatic test_abort();
        do_reset();
        stat_req = 1'b1;
        steps(3);
        tests++;
        if (busy !== 1'b1 || owner !== 1'b1 || tro_enable !== 1'b1) begin
            fails++;
            $display("FAIL abort_granted: got busy=%b owner=%b en=%b expected 1 1 1", busy, owner, tro_enable);
        end
        stat_req = 1'b0;
        steps(3);
        tests++;
        if (busy !== 1'b0 || tro_enable !== 1'b0 || gen_cnt + stat_cnt !== 0) begin
            fails++;
            $display("FAIL abort_idle: got busy=%b en=%b valids=%0d expected 0 0 0", busy, tro_enable, gen_cnt + stat_cnt);
        end
        gen_req = 1'b1; stat_req = 1'b1;
        step();
        tests++;
        if (owner !== 1'b0) begin
            fails++;
            $display("FAIL abort_tie_reset: got %b expected 0", owner);
        end
        gen_req = 1'b0; stat_req = 1'b0;
        steps(3);
        // Serve gen, abort a stat grant, then a tie must still favour stat.
        gen_req = 1'b1;
        step();
        ro_pulse(64'h1);
        ro_pulse(64'h2);
        steps(2);
        stat_req = 1'b1;
        steps(3);
        stat_req = 1'b0;
        steps(3);
        gen_req = 1'b1; stat_req = 1'b1;
        step();
        tests++;
        if (owner !== 1'b1) begin
            fails++;
            $display("FAIL abort_pointer_kept: got %b expected 1", owner);
        end
        gen_req = 1'b0; stat_req = 1'b0;
        steps(3);
    endtask

    task automatic test_ready_high();
        do_reset();
        tro_word  = 64'h6666_6666_6666_6666;
        tro_ready = 1'b1;
        gen_req   = 1'b1;
        steps(4);
        tro_ready = 1'b0;
        steps(4);
        ro_pulse(64'h7777_7777_7777_7777);
        ro_pulse(64'h8888_8888_8888_8888);
        steps(3);
        tests++;
        if (gen_cnt !== 1 || gen_word !== 64'h8888_8888_8888_8888) begin
            fails++;
            $display("FAIL ready_prehigh: got cnt=%0d word=%h expected 1 8888888888888888", gen_cnt, gen_word);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
`ifdef TRNG_SCHED_TIMEOUT_EN
        gen_req = 1'b1;
        step();
        ro_pulse(64'h1234);
        ro_pulse(64'h5678);
        steps(2);
        clear_mon();
        gen_req = 1'b1;
        step();
        n = 1;
        while (!gen_valid && n < 40) begin
            step();
            n++;
        end
        tests++;
        if (n !== 33) begin
            fails++;
            $display("FAIL timeout_latency: got %0d expected 33", n);
        end
        tests++;
        if (rnd_word !== 64'h0 || timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_result: got word=%h err=%b expected 0 1", rnd_word, timeout_err);
        end
        steps(5);
        tests++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || gen_cnt !== 1) begin
            fails++;
            $display("FAIL timeout_sticky: got err=%b busy=%b cnt=%0d expected 1 0 1", timeout_err, busy, gen_cnt);
        end
        do_reset();
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: got %b expected 0", timeout_err);
        end
`else
        gen_req = 1'b1;
        steps(50);
        tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || gen_cnt !== 0) begin
            fails++;
            $display("FAIL no_timeout: got err=%b busy=%b cnt=%0d expected 0 1 0", timeout_err, busy, gen_cnt);
        end
        gen_req = 1'b0;
        steps(3);
        n = 0;
`endif
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        stat_req = 1'b1;
        step();
        ro_pulse(64'h9999);
        ro_pulse(64'hABCD);
        steps(2);
        tests++;
        if (rnd_word !== 64'hABCD) begin
            fails++;
            $display("FAIL rst_pre_word: got %h expected abcd", rnd_word);
        end
        clear_mon();
        stat_req = 1'b1;
        steps(3);
        tests++;
        if (tro_enable !== 1'b1 || owner !== 1'b1) begin
            fails++;
            $display("FAIL rst_in_wait: got en=%b owner=%b expected 1 1", tro_enable, owner);
        end
        #3;
        trng_rst_n = 1'b0;
        #1;
        tests++;
        if ({gen_valid, stat_valid, owner, busy, tro_enable, timeout_err} !== 6'b0 || rnd_word !== 64'h0) begin
            fails++;
            $display("FAIL rst_async: got %b word=%h expected 000000 0", {gen_valid, stat_valid, owner, busy, tro_enable, timeout_err}, rnd_word);
        end
        stat_req = 1'b0;
        step();
        trng_rst_n = 1'b1;
        ro_pulse(64'hDEAD);
        ro_pulse(64'hBEEF);
        steps(3);
        tests++;
        if (gen_cnt + stat_cnt !== 0 || busy !== 1'b0 || tro_enable !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_valid: got valids=%0d busy=%b en=%b expected 0 0 0", gen_cnt + stat_cnt, busy, tro_enable);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_gen_only();
        test_tie();
        test_abort();
        test_ready_high();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1);
    end

endmodule

// File: doc/trng_req_scheduler.md
# trng_req_scheduler

Schedules and shares the ring-oscillator entropy source between two requesters: the bit-generation path (BRAM fill) and the on-chip statistical test. Grants the source round-robin and drives its enable. Synchronizes the source's asynchronous ready strobe, discards warm-up words, and delivers one captured 64-bit word per grant with a single-cycle valid pulse. Sits between the TRNG wrapper control logic and the RO entropy source, replacing the static enable mux.

## Interface
- WORD_W, 64, width of a random word
- DISCARD_WORDS, 1, words dropped after each enable before capture (0..15)
- TIMEOUT_CYC, 4096, max cycles waiting for one ready edge (used only with the timeout feature)

- clk  in  1  system clock
- trng_rst_n  in  1  reset, asynchronous, active-low
- gen_req  in  1  bit-gen wants one word; level, held until gen_valid
- stat_req  in  1  statistical test wants one word; level, held until stat_valid
- gen_valid  out  1  one-cycle pulse: rnd_word is for bit-gen
- stat_valid  out  1  one-cycle pulse: rnd_word is for stat test
- rnd_word  out  WORD_W  captured word; held until the next capture
- owner  out  1  current/last grant, 0=gen, 1=stat
- busy  out  1  high in any state except IDLE
- tro_enable  out  1  RO enable
- tro_word  in  WORD_W  RO word; stable ≥4 clk cycles after tro_ready rises
- tro_ready  in  1  RO ready, asynchronous to clk
- timeout_err  out  1  sticky watchdog flag

## Operation
- Reset values: all outputs 0; owner=0; last-served pointer = stat, so gen wins the first tie.
- States: IDLE, WAIT, DELIVER.
- IDLE: tro_enable=0. If one request is high, grant it. If both are high, grant the one not last served. Load discard_cnt=DISCARD_WORDS, set owner, go WAIT.
- WAIT: tro_enable=1. Act on each synchronized rising edge of tro_ready:
  - discard_cnt>0: decrement and stay in WAIT.
  - discard_cnt=0: capture tro_word into rnd_word and go DELIVER.
- WAIT abort: if the owner's request drops, return to IDLE. No valid, no capture, and the last-served pointer is unchanged.
- DELIVER: pulse the owner's valid for one cycle. tro_enable=0. Last-served pointer is set to owner. Go IDLE.
- Request rising during DELIVER for the same owner is treated as a new request in IDLE.
- Ready synchronizer: 2 flops (s1, s2) plus history flop s3. The edge condition is s2 & ~s3.
- A ready level that is already high on entry to WAIT does not count as an edge.
- Counters are unsigned. discard_cnt is 4 bits. The timeout counter is clog2(TIMEOUT_CYC+1) bits and saturates, with no wrap.

## Timing
- Request to tro_enable high: 1 cycle (IDLE → WAIT registered).
- tro_ready first sampled high by s1 at cycle k:
  - edge detected at k+2
  - rnd_word updated at k+3 together with the valid pulse
- tro_enable is low for ≥2 consecutive cycles (DELIVER and IDLE) between grants. This forces an RO restart.
- Maximum of one valid pulse per grant. gen_valid and stat_valid are never high together.
- Reset asserted mid-WAIT: tro_enable drops asynchronously and the in-flight word is lost.

## Configuration
- TRNG_SCHED_TIMEOUT_EN defined:
  - A cycle counter clears on entry to WAIT and on every accepted ready edge.
  - When it reaches TIMEOUT_CYC, the block sets timeout_err (sticky until reset), forces rnd_word=0, and goes DELIVER. The owner therefore still gets its valid pulse and does not hang.
- TRNG_SCHED_TIMEOUT_EN undefined: no counter; timeout_err is tied 0; WAIT can last indefinitely.

## Structure
- Shared package trng_pkg holds:
  - state enum (IDLE, WAIT, DELIVER)
  - owner encoding constants (OWNER_GEN=0, OWNER_STAT=1)
  - default WORD_W
- Sub-module trng_ready_sync: 3-flop synchronizer with rising-edge output and async active-low reset.

## Test plan
- gen_req only, DISCARD_WORDS=1, RO model pulses ready twice with words A then B → B on rnd_word, one gen_valid pulse, tro_enable low the next cycle.
- gen_req and stat_req high from reset, held → gen served first, then stat; owner 0 then 1; valids in separate cycles.
- stat_req drops during WAIT before any edge → no valid; next gen_req/stat_req tie still goes to gen.
- tro_ready already high when WAIT is entered → ignored; the capture happens on the next real rising edge.
- TRNG_SCHED_TIMEOUT_EN, TIMEOUT_CYC=32, RO never ready → gen_valid at cycle 33 after WAIT entry, rnd_word=0, timeout_err=1 until trng_rst_n low.
- trng_rst_n pulsed low mid-WAIT → all outputs 0 immediately; no valid after release until a new request.
